mem_arbiter: RTL and testbench

//  Shares the single line-wide memory_module between the instruction cache (read-only) and the

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_arbiter2.sv | 25 ++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I-cache / D-cache memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT_I,
        ARB_GRANT_D
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;

    localparam int CACHE_LINE_SIZE_DEF = 128;
    localparam int ADDR_WIDTH_DEF      = 32;

    // Bit position of each requester in the request/mask vectors.
    localparam int REQ_BIT_I = 0;
    localparam int REQ_BIT_D = 1;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: masked requests, ties go to the port not granted last.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    input  logic [1:0] mask,
    output logic       grant_valid,
    output req_id_t    grant_id
);

    logic [1:0] eligible;

    always_comb begin
        eligible    = req & ~mask;
        grant_valid = |eligible;
        grant_id    = REQ_I;
        if (eligible[REQ_BIT_I] && eligible[REQ_BIT_D]) begin
            grant_id = (last == REQ_D) ? REQ_I : REQ_D;
        end else if (eligible[REQ_BIT_D]) begin
            grant_id = REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache: round-robin grant,
// request latched for the whole transaction, completion steered back to the granted cache.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = CACHE_LINE_SIZE_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_icache_read_en,
    input  logic [ADDR_WIDTH-1:0]      in_icache_addr,
    output logic [CACHE_LINE_SIZE-1:0] out_icache_read_data,
    output logic                       out_icache_ready,
    input  logic                       in_dcache_read_en,
    input  logic                       in_dcache_write_en,
    input  logic [ADDR_WIDTH-1:0]      in_dcache_addr,
    input  logic [CACHE_LINE_SIZE-1:0] in_dcache_write_data,
    output logic [CACHE_LINE_SIZE-1:0] out_dcache_read_data,
    output logic                       out_dcache_ready,
    output logic                       out_mem_read_en,
    output logic                       out_mem_write_en,
    output logic [ADDR_WIDTH-1:0]      out_mem_addr,
    output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
    input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
    input  logic                       in_mem_ready
);

    arb_state_t                 state, state_next;
    req_id_t                    last_grant, last_grant_next;
    logic [1:0]                 hold_mask, hold_mask_next;
    logic [ADDR_WIDTH-1:0]      lat_addr, lat_addr_next;
    logic [CACHE_LINE_SIZE-1:0] lat_wdata, lat_wdata_next;
    logic                       lat_read, lat_read_next;
    logic                       lat_write, lat_write_next;
    logic [CACHE_LINE_SIZE-1:0] idata_q, ddata_q;

    logic    complete_i, complete_d;
    logic    grant_valid;
    req_id_t grant_id;
    logic    active;

    rr_arbiter2 u_rr (
        .req         ({in_dcache_read_en | in_dcache_write_en, in_icache_read_en}),
        .last        (last_grant),
        .mask        (hold_mask),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        hold_mask_next  = hold_mask;
        lat_addr_next   = lat_addr;
        lat_wdata_next  = lat_wdata;
        lat_read_next   = lat_read;
        lat_write_next  = lat_write;
        complete_i      = 1'b0;
        complete_d      = 1'b0;

        unique case (state)
            ARB_IDLE: begin
                // The completed port is masked for exactly one idle cycle so a stale enable
                // cannot immediately win again.
                hold_mask_next = '0;
                if (grant_valid) begin
                    last_grant_next = grant_id;
                    if (grant_id == REQ_I) begin
                        state_next     = ARB_GRANT_I;
                        lat_addr_next  = in_icache_addr;
                        lat_wdata_next = '0;
                        lat_read_next  = 1'b1;
                        lat_write_next = 1'b0;
                    end else begin
                        state_next     = ARB_GRANT_D;
                        lat_addr_next  = in_dcache_addr;
                        lat_wdata_next = in_dcache_write_data;
                        lat_write_next = in_dcache_write_en;
                        lat_read_next  = in_dcache_read_en & ~in_dcache_write_en;
                    end
                end
            end
            ARB_GRANT_I: begin
                if (in_mem_ready) begin
                    complete_i     = 1'b1;
                    state_next     = ARB_IDLE;
                    hold_mask_next = 2'b01;
                end
            end
            ARB_GRANT_D: begin
                if (in_mem_ready) begin
                    complete_d     = 1'b1;
                    state_next     = ARB_IDLE;
                    hold_mask_next = 2'b10;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        active             = (state != ARB_IDLE) && !reset;
        out_mem_read_en    = active & lat_read;
        out_mem_write_en   = active & lat_write;
        out_mem_addr       = active ? lat_addr  : '0;
        out_mem_write_data = active ? lat_wdata : '0;

        out_icache_ready   = complete_i & ~reset;
        out_dcache_ready   = complete_d & ~reset;

        // Completion data passes straight through; otherwise the last completed line is held.
        out_icache_read_data = '0;
        out_dcache_read_data = '0;
        if (!reset) begin
            out_icache_read_data = complete_i ? in_mem_read_data : idata_q;
            out_dcache_read_data = complete_d ? in_mem_read_data : ddata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= REQ_D;
            hold_mask  <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_read   <= 1'b0;
            lat_write  <= 1'b0;
            idata_q    <= '0;
            ddata_q    <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            hold_mask  <= hold_mask_next;
            lat_addr   <= lat_addr_next;
            lat_wdata  <= lat_wdata_next;
            lat_read   <= lat_read_next;
            lat_write  <= lat_write_next;
            if (complete_i) idata_q <= in_mem_read_data;
            if (complete_d) ddata_q <= in_mem_read_data;
        end
    end

    a_no_ready_in_idle: assert property (@(posedge clk) disable iff (reset)
        !(state == ARB_IDLE && in_mem_ready));

    a_no_dcache_read_and_write: assert property (@(posedge clk) disable iff (reset)
        !(in_dcache_read_en && in_dcache_write_en));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a simple fixed-latency line memory behind it.
module tb_mem_arbiter;

    localparam int LINE = 128;
    localparam int AW   = 32;
    localparam int LAT  = 2;

    localparam logic [LINE-1:0] L_SEQ  = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [LINE-1:0] L_DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_icache_read_en;
    logic [AW-1:0]   in_icache_addr;
    logic [LINE-1:0] out_icache_read_data;
    logic            out_icache_ready;
    logic            in_dcache_read_en;
    logic            in_dcache_write_en;
    logic [AW-1:0]   in_dcache_addr;
    logic [LINE-1:0] in_dcache_write_data;
    logic [LINE-1:0] out_dcache_read_data;
    logic            out_dcache_ready;
    logic            out_mem_read_en;
    logic            out_mem_write_en;
    logic [AW-1:0]   out_mem_addr;
    logic [LINE-1:0] out_mem_write_data;
    logic [LINE-1:0] in_mem_read_data;
    logic            in_mem_ready;

    always #5 clk = ~clk;

    mem_arbiter #(.CACHE_LINE_SIZE(LINE), .ADDR_WIDTH(AW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_icache_read_en    (in_icache_read_en),
        .in_icache_addr       (in_icache_addr),
        .out_icache_read_data (out_icache_read_data),
        .out_icache_ready     (out_icache_ready),
        .in_dcache_read_en    (in_dcache_read_en),
        .in_dcache_write_en   (in_dcache_write_en),
        .in_dcache_addr       (in_dcache_addr),
        .in_dcache_write_data (in_dcache_write_data),
        .out_dcache_read_data (out_dcache_read_data),
        .out_dcache_ready     (out_dcache_ready),
        .out_mem_read_en      (out_mem_read_en),
        .out_mem_write_en     (out_mem_write_en),
        .out_mem_addr         (out_mem_addr),
        .out_mem_write_data   (out_mem_write_data),
        .in_mem_read_data     (in_mem_read_data),
        .in_mem_ready         (in_mem_ready)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model: byte store, default byte value = addr & 0xFF
    logic [7:0] mem [logic [31:0]];
    int         mcnt = 0;

    function automatic logic [LINE-1:0] mem_line(input logic [31:0] a);
        logic [LINE-1:0] l;
        logic [31:0]     ba;
        l = '0;
        for (int i = 0; i < LINE / 8; i++) begin
            ba = a + 32'(i);
            l[8*i +: 8] = mem.exists(ba) ? mem[ba] : ba[7:0];
        end
        return l;
    endfunction

    initial begin
        in_mem_ready     = 1'b0;
        in_mem_read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            in_mem_ready = 1'b0;
            if (reset) begin
                mcnt = 0;
            end else if (out_mem_read_en || out_mem_write_en) begin
                if (mcnt == LAT) begin
                    if (out_mem_write_en) begin
                        for (int i = 0; i < LINE / 8; i++)
                            mem[out_mem_addr + 32'(i)] = out_mem_write_data[8*i +: 8];
                    end else begin
                        in_mem_read_data = mem_line(out_mem_addr);
                    end
                    in_mem_ready = 1'b1;
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // ---------------- scoreboard
    typedef struct {
        bit              is_d;
        logic [LINE-1:0] data;
        bit              chk_data;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always @(negedge clk) begin
        if (!reset && (out_icache_ready || out_dcache_ready)) begin
            if (out_icache_ready && out_dcache_ready)
                check("single_ready", 1'b1, 1'b0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got i=%0b d=%0b expected no ready", out_icache_ready, out_dcache_ready);
            end else begin
                e = sb.pop_front();
                check("ready_port_is_d", out_dcache_ready, e.is_d);
                if (e.chk_data)
                    check("ready_data", e.is_d ? out_dcache_read_data : out_icache_read_data, e.data);
            end
        end
    end

    // ---------------- requester helpers
    task automatic wait_ready(input bit is_d, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = is_d ? out_dcache_ready : out_icache_ready;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ready expected ready within 40 cycles", name);
        end
    endtask

    task automatic i_read(input logic [AW-1:0] a, input string name);
        @(posedge clk); #1;
        in_icache_read_en = 1'b1;
        in_icache_addr    = a;
        wait_ready(1'b0, name);
        @(posedge clk); #1;
        in_icache_read_en = 1'b0;
    endtask

    task automatic d_read(input logic [AW-1:0] a, input string name);
        @(posedge clk); #1;
        in_dcache_read_en = 1'b1;
        in_dcache_addr    = a;
        wait_ready(1'b1, name);
        @(posedge clk); #1;
        in_dcache_read_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset              = 1'b1;
        in_icache_read_en  = 1'b0;
        in_dcache_read_en  = 1'b0;
        in_dcache_write_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        bit seen;

        reset                = 1'b1;
        in_icache_read_en    = 1'b0;
        in_icache_addr       = '0;
        in_dcache_read_en    = 1'b0;
        in_dcache_write_en   = 1'b0;
        in_dcache_addr       = '0;
        in_dcache_write_data = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_read_en", out_mem_read_en, 1'b0);
        check("rst_mem_write_en", out_mem_write_en, 1'b0);
        check("rst_mem_addr", out_mem_addr, '0);
        check("rst_readies", {out_icache_ready, out_dcache_ready}, 2'b00);
        @(posedge clk); #1 reset = 1'b0;

        // 1: I-only read with one-cycle arbitration latency
        sb.push_back('{is_d: 1'b0, data: L_SEQ, chk_data: 1'b1});
        @(posedge clk); #1;
        in_icache_read_en = 1'b1;
        in_icache_addr    = 32'h100;
        @(negedge clk);
        check("t1_not_yet_granted", out_mem_read_en, 1'b0);
        @(negedge clk);
        check("t1_mem_read_en", out_mem_read_en, 1'b1);
        check("t1_mem_addr", out_mem_addr, 32'h100);
        wait_ready(1'b0, "t1");
        @(posedge clk); #1 in_icache_read_en = 1'b0;
        @(negedge clk);
        check("t1_idle_after", out_mem_read_en, 1'b0);
        check("t1_held_idata", out_icache_read_data, L_SEQ);

        // 2: contention right after reset, I wins first
        do_reset();
        sb.push_back('{is_d: 1'b0, data: L_SEQ, chk_data: 1'b1});
        sb.push_back('{is_d: 1'b1, data: L_SEQ, chk_data: 1'b1});
        fork
            i_read(32'h100, "t2_i");
            d_read(32'h200, "t2_d");
        join

        // 3: both hold requests -> I, D, I, D
        repeat (2) @(posedge clk);
        sb.push_back('{is_d: 1'b0, data: L_SEQ, chk_data: 1'b1});
        sb.push_back('{is_d: 1'b1, data: L_SEQ, chk_data: 1'b1});
        sb.push_back('{is_d: 1'b0, data: L_SEQ, chk_data: 1'b1});
        sb.push_back('{is_d: 1'b1, data: L_SEQ, chk_data: 1'b1});
        @(posedge clk); #1;
        in_icache_read_en = 1'b1;
        in_icache_addr    = 32'h100;
        in_dcache_read_en = 1'b1;
        in_dcache_addr    = 32'h200;
        got = 0;
        for (int n = 0; n < 200 && got < 4; n++) begin
            @(negedge clk);
            if (out_icache_ready || out_dcache_ready) got++;
        end
        @(posedge clk); #1;
        in_icache_read_en = 1'b0;
        in_dcache_read_en = 1'b0;
        check("t3_four_grants", got, 4);

        // 4: write-back then read the same line via the I side
        repeat (2) @(posedge clk);
        sb.push_back('{is_d: 1'b1, data: '0, chk_data: 1'b0});
        @(posedge clk); #1;
        in_dcache_write_en   = 1'b1;
        in_dcache_addr       = 32'h100;
        in_dcache_write_data = L_DEAD;
        @(negedge clk);
        @(negedge clk);
        check("t4_mem_write_en", out_mem_write_en, 1'b1);
        check("t4_mem_read_en", out_mem_read_en, 1'b0);
        check("t4_mem_addr", out_mem_addr, 32'h100);
        check("t4_mem_wdata", out_mem_write_data, L_DEAD);
        wait_ready(1'b1, "t4_w");
        @(posedge clk); #1 in_dcache_write_en = 1'b0;
        sb.push_back('{is_d: 1'b0, data: L_DEAD, chk_data: 1'b1});
        i_read(32'h100, "t4_r");

        // 5: address change during the transaction is ignored
        repeat (2) @(posedge clk);
        sb.push_back('{is_d: 1'b1, data: L_SEQ, chk_data: 1'b1});
        @(posedge clk); #1;
        in_dcache_read_en = 1'b1;
        in_dcache_addr    = 32'h200;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 in_dcache_addr = 32'h300;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = out_dcache_ready;
            check("t5_addr_stable", out_mem_addr, 32'h200);
        end
        if (!seen) check("t5_ready_seen", 1'b0, 1'b1);
        @(posedge clk); #1 in_dcache_read_en = 1'b0;

        // 6: reset while D is granted
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        in_dcache_read_en = 1'b1;
        in_dcache_addr    = 32'h200;
        @(negedge clk);
        @(negedge clk);
        check("t6_granted", out_mem_read_en, 1'b1);
        @(posedge clk); #2;
        reset             = 1'b1;
        in_dcache_read_en = 1'b0;
        @(negedge clk);
        check("t6_rst_read_en", out_mem_read_en, 1'b0);
        check("t6_rst_addr", out_mem_addr, '0);
        check("t6_rst_idata", out_icache_read_data, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_no_ready", {out_icache_ready, out_dcache_ready}, 2'b00);
        sb.push_back('{is_d: 1'b0, data: L_DEAD, chk_data: 1'b1});
        i_read(32'h100, "t6_r");

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
